demux_14_stream: RTL and testbench
==================================

Name: demux_14_stream

Overview:
- 1-to-4 streaming demultiplexer: the inverse of the team's 4:1 mux path.
- Accepts one valid/ready input stream and routes each word to one of four output lanes selected by `sel`.
- Each lane has a single-entry output register with independent valid/ready handshake, plus a wrapping delivered-word counter.
- Sits between a shared producer and four independent consumers.

Parameters:
- DATA_W, 8, width of the data word.
- CNT_W, 8, width of each per-lane delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  input word.
- sel  input  2  destination lane for the current input word; sampled with in_valid.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input word this cycle.
- out_0 .. out_3  output  DATA_W each  lane data registers.
- out_valid  output  4  per-lane valid; bit N belongs to out_N.
- out_ready  input  4  per-lane consumer ready; bit N belongs to out_N.
- cnt_0 .. cnt_3  output  CNT_W each  count of words delivered on lane N; wraps.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 4'b0000, out_0..out_3 = 0, cnt_0..cnt_3 = 0. in_ready is combinational and therefore reads 0 only if the rule below yields 0.
- Reset mid-transfer: any held word is discarded without being counted.
- Lane N is "free" when out_valid[N] = 0, or when out_valid[N] = 1 and out_ready[N] = 1 in the same cycle (pass-through of a drain).
- Ready rule: in_ready = free[sel], combinational. No dependency on in_valid.
- Input accept: an input handshake occurs when in_valid = 1 and in_ready = 1.
  - On the next edge, out_[sel] <= in_data and out_valid[sel] <= 1.
  - Latency: one cycle from accept to out_valid.
- Output delivery: a delivery occurs on lane N when out_valid[N] = 1 and out_ready[N] = 1.
  - On that edge, cnt_N <= cnt_N + 1, modulo 2^CNT_W (all-ones wraps to 0).
  - If lane N is not accepting a new word on the same edge, out_valid[N] <= 0.
- Simultaneous deliver + accept on the same lane: out_valid[N] stays 1, out_N takes the new word, and cnt_N increments. Full throughput is one word per cycle per lane.
- Deliveries on different lanes in the same cycle are independent. All four lanes may deliver together.
- Stalled lane, out_valid[N] = 1 and out_ready[N] = 0:
  - out_N and out_valid[N] hold stable.
  - Input targeting lane N stalls (in_ready = 0).
  - Input targeting other free lanes proceeds.
- sel change while in_valid = 1 and not accepted: allowed. in_ready re-evaluates on the new sel. Protocol stability of sel is the producer's responsibility.
- Data hold: out_N changes only on an accept to lane N. The data register is not cleared on delivery.
- No combinational path from in_data to any output.

Test Plan:
- Reset, then route: rst_n low 2 cycles, release; drive in_data=8'hA5 with sel=2, in_valid=1, out_ready=4'hF.
  -> in_ready=1; next cycle out_valid=4'b0100, out_2=8'hA5; following cycle cnt_2=1 and out_valid=0.
- Back-to-back streaming: sel=1, in_valid held 1, out_ready[1]=1, data 1..10 on consecutive cycles.
  -> in_ready constantly 1; out_1 shows 1..10 on consecutive cycles; cnt_1=10.
- Backpressure isolation: load 8'h11 on lane 0 with out_ready[0]=0, then present sel=0, then sel=3 with 8'h33.
  -> in_ready=0 for sel=0; lane 3 accepts 8'h33; out_0 holds 8'h11 until out_ready[0]=1, then cnt_0=1.
- Counter wrap, CNT_W=8: deliver 256 words on lane 3.
  -> cnt_3 reaches 8'hFF, then reads 8'h00 after the 256th delivery; other counters stay 0.
- Parallel drain: fill all four lanes with out_ready=0, then set out_ready=4'hF for one cycle.
  -> all four counters increment by 1 on the same edge; out_valid=4'b0000 next cycle.
- Reset mid-operation: lanes 0 and 2 valid and stalled; pulse rst_n low asynchronously, between clock edges.
  -> out_valid=0 and all counters 0 immediately, without waiting for a clock edge; no delivery counted.

Source files
------------

// File: rtl/demux_14_stream.sv
// ---------------------------------------------------------------------------
// demux_14_stream
//   1-to-4 streaming demultiplexer. One valid/ready input stream is routed,
//   word by word, to one of four output lanes chosen by `sel`. Each lane owns
//   a single-entry output register with its own valid/ready handshake and a
//   wrapping count of words delivered to its consumer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    input word (DATA_W)
//   sel        destination lane of the current input word
//   in_valid   input word valid
//   in_ready   input can be accepted this cycle (combinational, from sel)
//   out_0..3   lane data registers (DATA_W each)
//   out_valid  per-lane valid, bit N belongs to out_N
//   out_ready  per-lane consumer ready, bit N belongs to out_N
//   cnt_0..3   per-lane delivered-word counters (CNT_W each, wrapping)
// ---------------------------------------------------------------------------
module demux_14_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_0,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [CNT_W-1:0]  cnt_0,
    output logic [CNT_W-1:0]  cnt_1,
    output logic [CNT_W-1:0]  cnt_2,
    output logic [CNT_W-1:0]  cnt_3
);

    logic [DATA_W-1:0] data_r [4];
    logic [CNT_W-1:0]  cnt_r  [4];
    logic [3:0]        valid_r;

    logic [3:0]        free_s;
    logic [3:0]        deliver_s;
    logic [3:0]        load_s;
    logic [3:0]        valid_nxt_s;
    logic              accept_s;

    // Lane handshake decode: a lane is free when empty or draining this cycle,
    // so a full lane whose consumer is ready can take a new word back-to-back.
    always_comb begin
        free_s      = ~valid_r | out_ready;
        deliver_s   = valid_r & out_ready;
        accept_s    = in_valid & free_s[sel];
        load_s      = 4'b0000;
        valid_nxt_s = valid_r;
        for (int i = 0; i < 4; i++) begin
            if (accept_s && (sel == 2'(i))) begin
                load_s[i] = 1'b1;
            end else begin
                load_s[i] = 1'b0;
            end
            // A new word wins over a drain: valid stays high across the edge.
            if (load_s[i]) begin
                valid_nxt_s[i] = 1'b1;
            end else if (deliver_s[i]) begin
                valid_nxt_s[i] = 1'b0;
            end else begin
                valid_nxt_s[i] = valid_r[i];
            end
        end
    end

    // in_ready depends only on lane state and sel, never on in_valid or in_data.
    assign in_ready = free_s[sel];

    // Lane registers: data loads only on accept, counters step on delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_r[i] <= {DATA_W{1'b0}};
                cnt_r[i]  <= {CNT_W{1'b0}};
            end
        end else begin
            valid_r <= valid_nxt_s;
            for (int i = 0; i < 4; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= in_data;
                end
                if (deliver_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign out_valid = valid_r;
    assign out_0     = data_r[0];
    assign out_1     = data_r[1];
    assign out_2     = data_r[2];
    assign out_3     = data_r[3];
    assign cnt_0     = cnt_r[0];
    assign cnt_1     = cnt_r[1];
    assign cnt_2     = cnt_r[2];
    assign cnt_3     = cnt_r[3];

endmodule

// File: tb/tb_demux_14_stream.sv
module tb_demux_14_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_0, out_1, out_2, out_3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  cnt_0, cnt_1, cnt_2, cnt_3;

    int n_vec;
    int n_err;

    logic [7:0] exp_q [4][$];
    logic [7:0] exp_cnt [4];
    logic [7:0] outs [4];
    logic [7:0] cnts [4];

    demux_14_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_0     (cnt_0),
        .cnt_1     (cnt_1),
        .cnt_2     (cnt_2),
        .cnt_3     (cnt_3)
    );

    assign outs[0] = out_0;
    assign outs[1] = out_1;
    assign outs[2] = out_2;
    assign outs[3] = out_3;
    assign cnts[0] = cnt_0;
    assign cnts[1] = cnt_1;
    assign cnts[2] = cnt_2;
    assign cnts[3] = cnt_3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: counters checked every cycle, data popped per delivery.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                exp_q[i].delete();
                exp_cnt[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cnt_%0d", i), int'(cnts[i]), int'(exp_cnt[i]));
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("unexpected_delivery_%0d", i), int'(outs[i]), -1);
                    end else begin
                        chk($sformatf("out_%0d", i), int'(outs[i]), int'(exp_q[i].pop_front()));
                    end
                    exp_cnt[i] = exp_cnt[i] + 8'h01;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one word; check in_ready mid-cycle and queue it if it should go.
    task automatic send(input logic [1:0] lane, input logic [7:0] d, input logic exp_rdy);
        sel      = lane;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        if (exp_rdy) exp_q[lane].push_back(d);
        next_cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_data = 8'h00;
        sel = 2'd0;
        in_valid = 1'b0;
        out_ready = 4'hF;
        repeat (2) next_cycle();
        // Reset state.
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_0", int'(out_0), 0);
        chk("rst_out_3", int'(out_3), 0);
        chk("rst_cnt_0", int'(cnt_0), 0);
        chk("rst_cnt_2", int'(cnt_2), 0);
        rst_n = 1'b1;
        next_cycle();

        // Reset then route.
        send(2'd2, 8'hA5, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("route_out_valid", int'(out_valid), 4'b0100);
        chk("route_out_2", int'(out_2), 8'hA5);
        next_cycle();
        @(negedge clk);
        chk("route_valid_clr", int'(out_valid), 0);
        chk("route_cnt_2", int'(cnt_2), 1);
        next_cycle();

        // Back-to-back streaming on lane 1.
        for (int k = 1; k <= 10; k++) send(2'd1, 8'(k), 1'b1);
        idle(2);
        chk("stream_cnt_1", int'(cnt_1), 10);

        // Backpressure isolation.
        out_ready = 4'b1110;
        send(2'd0, 8'h11, 1'b1);
        send(2'd0, 8'h22, 1'b0);
        send(2'd3, 8'h33, 1'b1);
        idle(3);
        chk("stall_out_0", int'(out_0), 8'h11);
        chk("stall_valid_0", int'(out_valid[0]), 1);
        chk("stall_cnt_0", int'(cnt_0), 0);
        chk("stall_cnt_3", int'(cnt_3), 1);
        out_ready = 4'hF;
        idle(2);
        chk("unstall_cnt_0", int'(cnt_0), 1);
        chk("unstall_valid", int'(out_valid), 0);

        // Counter wrap on lane 3.
        do_reset();
        for (int k = 0; k < 255; k++) send(2'd3, 8'(k), 1'b1);
        idle(2);
        chk("wrap_cnt_ff", int'(cnt_3), 8'hFF);
        send(2'd3, 8'hEE, 1'b1);
        idle(2);
        chk("wrap_cnt_00", int'(cnt_3), 0);
        chk("wrap_cnt_0", int'(cnt_0), 0);
        chk("wrap_cnt_1", int'(cnt_1), 0);
        chk("wrap_cnt_2", int'(cnt_2), 0);

        // Parallel drain.
        out_ready = 4'h0;
        send(2'd0, 8'hC0, 1'b1);
        send(2'd1, 8'hC1, 1'b1);
        send(2'd2, 8'hC2, 1'b1);
        send(2'd3, 8'hC3, 1'b1);
        idle(1);
        chk("fill_valid", int'(out_valid), 4'hF);
        out_ready = 4'hF;
        next_cycle();
        out_ready = 4'h0;
        @(negedge clk);
        chk("drain_valid", int'(out_valid), 0);
        chk("drain_cnt_0", int'(cnt_0), 1);
        chk("drain_cnt_1", int'(cnt_1), 1);
        chk("drain_cnt_2", int'(cnt_2), 1);
        chk("drain_cnt_3", int'(cnt_3), 1);
        next_cycle();

        // Asynchronous reset mid-operation with stalled lanes 0 and 2.
        send(2'd0, 8'h5A, 1'b1);
        send(2'd2, 8'hC3, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", int'(out_valid), 4'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_cnt_0", int'(cnt_0), 0);
        chk("async_cnt_2", int'(cnt_2), 0);
        chk("async_out_0", int'(out_0), 0);
        #1;
        rst_n = 1'b1;
        out_ready = 4'hF;
        idle(2);
        chk("post_rst_cnt_0", int'(cnt_0), 0);
        chk("post_rst_cnt_2", int'(cnt_2), 0);
        chk("post_rst_valid", int'(out_valid), 0);

        for (int i = 0; i < 4; i++) chk($sformatf("leftover_%0d", i), exp_q[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
